// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared state encoding, CSR indices and mstatus bit positions for csr_trap_ctrl
package csr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_STATUS,
        T_VEC,
        M_STATUS,
        M_EPC
    } trap_state_e;

    localparam int CSR_MSTATUS = 0;
    localparam int CSR_MTVEC   = 1;
    localparam int CSR_MEPC    = 2;
    localparam int CSR_MCAUSE  = 3;

    localparam int MIE    = 3;
    localparam int MPIE   = 7;
    localparam int MPP_LO = 11;
    localparam int MPP_HI = 12;

endpackage

// File: rtl/mstatus_update.sv
// rtl/mstatus_update.sv - combinational mstatus rewrite for trap entry (is_mret=0) or mret (is_mret=1)
module mstatus_update
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] old_status,
    input  logic            is_mret,
    output logic [XLEN-1:0] new_status
);

    always_comb begin
        new_status = old_status;
        new_status[MPP_HI:MPP_LO] = 2'b11;
        if (is_mret) begin
            new_status[MIE]  = old_status[MPIE];
            new_status[MPIE] = 1'b1;
        end else begin
            new_status[MPIE] = old_status[MIE];
            new_status[MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - trap entry / mret sequencer owning the CSR file ports
// Optional vectored trap targets are enabled by defining CSR_TRAP_VECTORED_EN.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int CAUSE_W = 4,
    parameter int ADDR_W  = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               trap_valid,
    output logic               trap_ready,
    input  logic [XLEN-1:0]    trap_epc,
    input  logic [CAUSE_W-1:0] trap_cause,
    input  logic               mret_valid,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic [ADDR_W-1:0]  pipe_raddr,
    output logic [XLEN-1:0]    pipe_rdata,
    input  logic               pipe_wen,
    input  logic [ADDR_W-1:0]  pipe_waddr,
    input  logic [XLEN-1:0]    pipe_wdata,
    output logic               pipe_stall,
    output logic [ADDR_W-1:0]  csr_raddr,
    input  logic [XLEN-1:0]    csr_rdata,
    output logic               csr_wen,
    output logic [ADDR_W-1:0]  csr_waddr,
    output logic [XLEN-1:0]    csr_wdata,
    output logic               busy
);

    trap_state_e        state, next_state;
    logic [XLEN-3:0]    epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [XLEN-1:0]    status_new;
    logic [XLEN-1:0]    vec_base;
    logic [XLEN-1:0]    trap_target;
    logic               unused_epc_bits;

    // mepc is always word aligned, so the low epc bits are never stored
    assign unused_epc_bits = ^trap_epc[1:0];

    mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
        .old_status (csr_rdata),
        .is_mret    (state == M_STATUS),
        .new_status (status_new)
    );

    assign vec_base = {csr_rdata[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    assign trap_target = (csr_rdata[1:0] == 2'b01)
                       ? vec_base + (XLEN'(cause_q) << 2)
                       : vec_base;
`else
    assign trap_target = vec_base;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        next_state = state;
        trap_ready = 1'b0;
        pipe_stall = 1'b1;
        pipe_rdata = '0;
        csr_raddr  = ADDR_W'(CSR_MSTATUS);
        csr_wen    = 1'b0;
        csr_waddr  = ADDR_W'(CSR_MSTATUS);
        csr_wdata  = '0;
        case (state)
            IDLE: begin
                trap_ready = 1'b1;
                csr_raddr  = pipe_raddr;
                pipe_rdata = csr_rdata;
                csr_waddr  = pipe_waddr;
                csr_wdata  = pipe_wdata;
                // an accepting cycle drops the pipeline write; the pipeline retries it
                pipe_stall = trap_valid | mret_valid;
                csr_wen    = pipe_wen & ~pipe_stall;
                if (trap_valid)      next_state = T_EPC;
                else if (mret_valid) next_state = M_STATUS;
            end
            T_EPC: begin
                csr_wen    = 1'b1;
                csr_waddr  = ADDR_W'(CSR_MEPC);
                csr_wdata  = {epc_q, 2'b00};
                next_state = T_CAUSE;
            end
            T_CAUSE: begin
                csr_wen    = 1'b1;
                csr_waddr  = ADDR_W'(CSR_MCAUSE);
                csr_wdata  = XLEN'(cause_q);
                next_state = T_STATUS;
            end
            T_STATUS, M_STATUS: begin
                csr_raddr  = ADDR_W'(CSR_MSTATUS);
                csr_wen    = 1'b1;
                csr_waddr  = ADDR_W'(CSR_MSTATUS);
                csr_wdata  = status_new;
                next_state = (state == T_STATUS) ? T_VEC : M_EPC;
            end
            T_VEC: begin
                csr_raddr  = ADDR_W'(CSR_MTVEC);
                next_state = IDLE;
            end
            M_EPC: begin
                csr_raddr  = ADDR_W'(CSR_MEPC);
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            epc_q          <= '0;
            cause_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= next_state;
            redirect_valid <= 1'b0;
            if (state == IDLE && trap_valid) begin
                epc_q   <= trap_epc[XLEN-1:2];
                cause_q <= trap_cause;
            end
            if (state == T_VEC) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= trap_target;
            end
            if (state == M_EPC) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= csr_rdata;
            end
        end
    end

endmodule
